// File: rtl/gru_fxp_pkg.sv
// Shared fixed-point types for the GRU datapath: Q8.8 signed words, guard-bit accumulator,
// accumulator FSM states and a sign-extension helper.
package gru_fxp_pkg;

  localparam int INT_WIDTH  = 8;
  localparam int FRAC_WIDTH = 8;
  localparam int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1;
  localparam int GUARD_BITS = 8;
  localparam int ACC_WIDTH  = WIDTH + GUARD_BITS;

  typedef logic signed [WIDTH-1:0]     fxp_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  function automatic acc_t sext(input fxp_t x);
    return {{GUARD_BITS{x[WIDTH-1]}}, x};
  endfunction

endpackage

// File: rtl/fxp_saturate.sv
// Narrows a guard-bit accumulator value to one fixed-point word and flags out-of-range sums.
// Build option GRU_ACC_SAT_EN: clamp to the word limits on overflow; otherwise wrap.
module fxp_saturate
  import gru_fxp_pkg::*;
(
  input  acc_t i_acc,
  output fxp_t o_data,
  output logic o_overflow
);

  localparam fxp_t FXP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam fxp_t FXP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // In range exactly when the guard bits all replicate the word's sign bit.
  logic [GUARD_BITS:0] w_hi;
  assign w_hi       = i_acc[ACC_WIDTH-1:WIDTH-1];
  assign o_overflow = ~((&w_hi) | (~|w_hi));

`ifdef GRU_ACC_SAT_EN
  always_comb begin
    o_data = i_acc[WIDTH-1:0];
    if (o_overflow) begin
      o_data = i_acc[ACC_WIDTH-1] ? FXP_MIN : FXP_MAX;
    end
  end
`else
  assign o_data = i_acc[WIDTH-1:0];
`endif

endmodule

// File: rtl/gru_dot_accumulator.sv
// Sums one vector of signed products plus a bias and emits one WIDTH-bit dot product per vector.
// Overflow handling of out_data follows GRU_ACC_SAT_EN (clamp when defined, wrap otherwise).
module gru_dot_accumulator
  import gru_fxp_pkg::*;
#(
  parameter int MAX_TERMS = 64,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fxp_t             in_data,
  input  logic             in_last,
  input  fxp_t             bias,
  output logic             out_valid,
  input  logic             out_ready,
  output fxp_t             out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow,
  output logic             out_cap,
  output acc_state_e       dbg_state
);

  if (MAX_TERMS > (2**GUARD_BITS) - 1) begin : g_bad_max_terms
    $error("MAX_TERMS exceeds what GUARD_BITS can sum without wrap");
  end

  acc_state_e       r_state;
  acc_state_e       w_next_state;
  acc_t             r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  fxp_t             r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_overflow;
  logic             r_out_cap;

  acc_t             w_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_close;
  logic             w_take;
  fxp_t             w_sat_data;
  logic             w_sat_ovf;

  // Handshake: a beat transfers on a rising edge where in_valid & in_ready; a result transfers
  // where out_valid & out_ready. Neither side's ready depends combinationally on its own valid.
  assign in_ready  = (r_state == ACCUM) & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_sum     = (r_cnt == '0) ? (sext(bias) + sext(in_data)) : (r_acc + sext(in_data));
  assign w_close   = w_accept & (in_last | (w_cnt_inc == CNT_W'(MAX_TERMS)));
  assign w_take    = (r_state == HOLD) & r_out_valid & out_ready;

  fxp_saturate u_sat (
    .i_acc      (w_sum),
    .o_data     (w_sat_data),
    .o_overflow (w_sat_ovf)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCUM:   if (w_close) w_next_state = HOLD;
      HOLD:    if (w_take)  w_next_state = ACCUM;
      default: w_next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
      r_out_cap      <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_cnt_inc;
      if (w_close) begin
        r_out_valid    <= 1'b1;
        r_out_data     <= w_sat_data;
        r_out_count    <= w_cnt_inc;
        r_out_overflow <= w_sat_ovf;
        r_out_cap      <= ~in_last;
      end
    end else if (w_take) begin
      r_out_valid <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;
  assign out_cap      = r_out_cap;
  assign dbg_state    = r_state;

endmodule
